serial_add_sub_digit: RTL and testbench

- Digit-serial two's-complement adder/subtractor: the next generation of the bit-serial adder.
- Consumes operands LSD-first, DIGIT_W bits per beat, with first/last word framing and valid-qualified stalls.
- Produces the result digit-serially with a registered carry/borrow and signed overflow at end of word.
- Sits between serialiser/deserialiser stages in the sequential-arithmetic datapath.

---
 rtl/serial_add_sub_digit.sv | 128 ++++++++++++
 tb/tb_serial_add_sub_digit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_digit.sv
// Digit-serial two's-complement adder/subtractor: LSD-first operands, DIGIT_W bits per beat,
// first/last word framing, registered carry/borrow chain and end-of-word signed overflow.
module serial_add_sub_digit #(
    parameter int DIGIT_W    = 1,
    parameter int MAX_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_overflow,
    output logic               out_err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state, state_nx;
    logic               carry, carry_nx;
    logic               mode, mode_nx;
    logic [CNT_W-1:0]   count, count_nx, count_inc;

    logic               eff_mode;
    logic [DIGIT_W-1:0] y;
    logic [DIGIT_W-1:0] digit_sum;
    logic               cin_msb;
    logic               cout;

    logic               valid_nx, last_nx, carry_out_nx, overflow_nx, err_nx;
    logic [DIGIT_W-1:0] sum_nx;

    // Ripple of full adders across the digit; a first beat restarts the chain from sub.
    always_comb begin
        logic cy;
        eff_mode  = in_first ? sub : mode;
        y         = b ^ {DIGIT_W{eff_mode}};
        digit_sum = '0;
        cin_msb   = 1'b0;
        // NOTE: cy is a stepping variable inside one combinational pass, so it is assigned
        // with blocking '='; registered state below always uses '<='.
        cy        = in_first ? sub : carry;
        for (int i = 0; i < DIGIT_W; i++) begin
            cin_msb      = cy;
            digit_sum[i] = a[i] ^ y[i] ^ cy;
            cy           = (a[i] & y[i]) | ((a[i] ^ y[i]) & cy);
        end
        cout = cy;
    end

    assign count_inc = in_first ? CNT_W'(1) : count + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nx     = state;
        carry_nx     = carry;
        mode_nx      = mode;
        count_nx     = count;
        valid_nx     = 1'b0;
        sum_nx       = '0;
        last_nx      = 1'b0;
        carry_out_nx = 1'b0;
        overflow_nx  = 1'b0;
        err_nx       = 1'b0;

        if (in_valid) begin
            if (!in_first && state == IDLE) begin
                err_nx = 1'b1;
            end else begin
                // A first beat while BUSY aborts the old word but still starts the new one.
                err_nx   = in_first && (state == BUSY);
                valid_nx = 1'b1;
                sum_nx   = digit_sum;
                carry_nx = cout;
                mode_nx  = eff_mode;
                if (in_last || count_inc == CNT_W'(MAX_DIGITS)) begin
                    last_nx      = 1'b1;
                    carry_out_nx = cout;
                    overflow_nx  = cin_msb ^ cout;
                    err_nx       = err_nx | !in_last;
                    count_nx     = '0;
                    state_nx     = IDLE;
                end else begin
                    count_nx = count_inc;
                    state_nx = BUSY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            carry        <= 1'b0;
            mode         <= 1'b0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_last     <= 1'b0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            carry        <= carry_nx;
            mode         <= mode_nx;
            count        <= count_nx;
            out_valid    <= valid_nx;
            out_sum      <= sum_nx;
            out_last     <= last_nx;
            out_carry    <= carry_out_nx;
            out_overflow <= overflow_nx;
            out_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_serial_add_sub_digit.sv
// Bench for serial_add_sub_digit: DIGIT_W=1 and DIGIT_W=4 instances share framing and are
// checked every cycle against a word-level integer model, plus directed literal results.
module tb_serial_add_sub_digit;

    localparam int MAXD = 8;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_first, in_last, sub;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic       v1, l1, c1, o1, e1;
    logic [0:0] s1;
    logic       v4, l4, c4, o4, e4;
    logic [3:0] s4;

    serial_add_sub_digit #(.DIGIT_W(1), .MAX_DIGITS(MAXD)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .sub(sub), .a(a1), .b(b1), .out_valid(v1), .out_sum(s1), .out_last(l1),
        .out_carry(c1), .out_overflow(o1), .out_err(e1));

    serial_add_sub_digit #(.DIGIT_W(4), .MAX_DIGITS(MAXD)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .sub(sub), .a(a4), .b(b4), .out_valid(v4), .out_sum(s4), .out_last(l4),
        .out_carry(c4), .out_overflow(o4), .out_err(e4));

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Word-level reference: the k digits received so far form n-bit integers; the result is
    // a + (sub ? ~b : b) + sub, with carry = bit n and overflow from operand/result signs.
    function automatic void word_calc(input longint unsigned aw, input longint unsigned bw,
                                      input int w, input int k, input bit md,
                                      output longint unsigned dig, output bit c, output bit o);
        int n;
        longint unsigned mask, yw, tot;
        bit sa, sy, ss;
        n    = w * k;
        mask = (64'd1 << n) - 64'd1;
        yw   = md ? (~bw & mask) : (bw & mask);
        tot  = (aw & mask) + yw + 64'(md);
        dig  = (tot >> (w * (k - 1))) & ((64'd1 << w) - 64'd1);
        c    = tot[n];
        sa   = aw[n-1];
        sy   = yw[n-1];
        ss   = tot[n-1];
        o    = (sa == sy) && (ss != sa);
    endfunction

    // Model state and expectations for the outputs after the next rising edge.
    bit              have_exp = 1'b0;
    bit              m_busy = 1'b0, m_mode = 1'b0;
    int              m_k = 0;
    longint unsigned m_a1, m_b1, m_a4, m_b4;
    bit              e_valid, e_last, e_err, e_first;
    longint unsigned e1_sum, e4_sum;
    bit              e1_c, e1_o, e4_c, e4_o;

    // DUT-captured word results used by the literal checks.
    longint unsigned cap1, cap4, fin1, fin4;
    int              pos1, pos4;
    bit              fc1, fo1, fc4, fo4;
    int              err_cnt = 0;

    always @(negedge clk) begin
        longint unsigned dig;
        bit acc, cc, oo;
        if (have_exp) begin
            check("w1_valid", 64'(v1), 64'(e_valid));
            check("w1_last", 64'(l1), 64'(e_last));
            check("w1_err", 64'(e1), 64'(e_err));
            check("w1_carry", 64'(c1), 64'(e1_c));
            check("w1_ovf", 64'(o1), 64'(e1_o));
            check("w4_valid", 64'(v4), 64'(e_valid));
            check("w4_last", 64'(l4), 64'(e_last));
            check("w4_err", 64'(e4), 64'(e_err));
            check("w4_carry", 64'(c4), 64'(e4_c));
            check("w4_ovf", 64'(o4), 64'(e4_o));
            if (e_valid) begin
                check("w1_sum", 64'(s1), e1_sum);
                check("w4_sum", 64'(s4), e4_sum);
            end
            if (e1) err_cnt++;
            if (v1) begin
                if (e_first) begin cap1 = 0; pos1 = 0; end
                cap1 |= 64'(s1) << pos1;
                pos1 += 1;
                if (l1) begin fin1 = cap1; fc1 = c1; fo1 = o1; end
            end
            if (v4) begin
                if (e_first) begin cap4 = 0; pos4 = 0; end
                cap4 |= 64'(s4) << pos4;
                pos4 += 4;
                if (l4) begin fin4 = cap4; fc4 = c4; fo4 = o4; end
            end
        end

        // Inputs are stable here until the coming rising edge samples them.
        {e_valid, e_last, e_err, e_first, e1_c, e1_o, e4_c, e4_o} = '0;
        e1_sum = 0;
        e4_sum = 0;
        acc    = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (in_valid) begin
            if (in_first) begin
                e_err  = m_busy;
                m_k    = 1;
                m_mode = sub;
                m_a1 = 64'(a1); m_b1 = 64'(b1); m_a4 = 64'(a4); m_b4 = 64'(b4);
                acc    = 1'b1;
            end else if (m_busy) begin
                m_a1 |= 64'(a1) << m_k;
                m_b1 |= 64'(b1) << m_k;
                m_a4 |= 64'(a4) << (4 * m_k);
                m_b4 |= 64'(b4) << (4 * m_k);
                m_k++;
                acc = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end
        if (acc) begin
            e_valid = 1'b1;
            e_first = in_first;
            m_busy  = 1'b1;
            word_calc(m_a1, m_b1, 1, m_k, m_mode, dig, cc, oo);
            e1_sum = dig;
            if (in_last || m_k == MAXD) begin e1_c = cc; e1_o = oo; end
            word_calc(m_a4, m_b4, 4, m_k, m_mode, dig, cc, oo);
            e4_sum = dig;
            if (in_last || m_k == MAXD) begin
                e4_c   = cc;
                e4_o   = oo;
                e_last = 1'b1;
                if (!in_last) e_err = 1'b1;
                m_busy = 1'b0;
            end
        end
        have_exp = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input bit f, input bit l, input bit s, input logic [0:0] x1,
                        input logic [0:0] y1, input logic [3:0] x4, input logic [3:0] y4);
        in_valid = 1'b1; in_first = f; in_last = l; sub = s;
        a1 = x1; b1 = y1; a4 = x4; b4 = y4;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] a1w, input logic [63:0] b1w,
                             input logic [63:0] a4w, input logic [63:0] b4w,
                             input int n, input bit s, input int gap, input bit end_last);
        for (int i = 0; i < n; i++) begin
            beat(i == 0, (i == n - 1) && end_last, s, a1w[i], b1w[i], a4w[4*i +: 4], b4w[4*i +: 4]);
            if (i < n - 1) idle(gap);
        end
    endtask

    initial begin
        int err0;
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sub = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        idle(2);
        check("reset_valid", 64'(v1), 0);
        check("reset_err", 64'(e4), 0);
        rst_n = 1'b1;
        idle(1);

        err0 = err_cnt;
        send_word(64'h5A, 64'h3C, 64'h1234_5678, 64'h9ABC_DEF0, 8, 1'b0, 0, 1'b1);
        idle(2);
        check("add_5a_3c_sum", fin1, 64'h96);
        check("add_5a_3c_carry", 64'(fc1), 0);
        check("add_5a_3c_ovf", 64'(fo1), 1);
        check("add_5a_3c_noerr", 64'(err_cnt - err0), 0);

        send_word(64'h10, 64'h20, 64'h0, 64'h1, 8, 1'b1, 0, 1'b1);
        idle(2);
        check("sub_10_20_sum", fin1, 64'hF0);
        check("sub_10_20_borrow", 64'(fc1), 0);
        check("sub_10_20_ovf", 64'(fo1), 0);
        send_word(64'h20, 64'h10, 64'h5, 64'h3, 8, 1'b1, 1, 1'b1);
        idle(2);
        check("sub_20_10_sum", fin1, 64'h10);
        check("sub_20_10_carry", 64'(fc1), 1);

        send_word(64'h3, 64'h1, 64'hFF, 64'h01, 2, 1'b0, 3, 1'b1);
        idle(2);
        check("w4_ff_01_sum", fin4, 64'h00);
        check("w4_ff_01_carry", 64'(fc4), 1);
        check("w4_ff_01_ovf", 64'(fo4), 0);

        err0 = err_cnt;
        send_word(64'hFF, 64'hFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3, 1'b0, 0, 1'b0);
        send_word(64'h01, 64'h01, 64'h01, 64'h01, 8, 1'b0, 0, 1'b1);
        idle(2);
        check("abort_sum", fin1, 64'h02);
        check("abort_carry", 64'(fc1), 0);
        check("abort_w4_sum", fin4, 64'h02);
        check("abort_err_pulses", 64'(err_cnt - err0), 1);

        send_word(64'hFF, 64'h00, 64'h0, 64'h0, 3, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        check("midreset_valid", 64'(v1), 0);
        check("midreset_err", 64'(e1), 0);
        rst_n = 1'b1;
        send_word(64'h7F, 64'h01, 64'h7FFF_FFFF, 64'h1, 8, 1'b0, 0, 1'b1);
        idle(2);
        check("rst_7f_01_sum", fin1, 64'h80);
        check("rst_7f_01_ovf", 64'(fo1), 1);
        check("rst_7f_01_carry", 64'(fc1), 0);

        err0 = err_cnt;
        beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h4);
        idle(1);
        check("orphan_err", 64'(err_cnt - err0), 1);
        err0 = err_cnt;
        send_word(64'h03, 64'h01, 64'h3, 64'h1, 9, 1'b0, 0, 1'b1);
        idle(2);
        check("overlong_sum", fin1, 64'h04);
        check("overlong_err_pulses", 64'(err_cnt - err0), 2);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_first = ($urandom_range(0, 4) == 0);
            in_last  = ($urandom_range(0, 4) == 0);
            sub      = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1; in_valid = 1'b0;
        idle(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
